// File: rtl/hazard_controller_pkg.sv
// Shared types and defaults for the pipeline hazard controller and its MULT/DIV busy timer.
package hazard_controller_pkg;

    localparam int unsigned MULT_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF  = 32;
    localparam int unsigned CNT_W_DEF    = 6;
    localparam int unsigned PERF_W_DEF   = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned CAUSE_W      = 2;

    typedef enum logic {
        HC_IDLE = 1'b0,
        HC_BUSY = 1'b1
    } hc_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_LOAD_USE = 2'b01,
        CAUSE_MD_STALL = 2'b10,
        CAUSE_REDIRECT = 2'b11
    } hc_cause_e;

    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_flush;
        logic idex_flush;
    } hc_ctrl_t;

    // Pipeline control pattern that goes with each hazard cause.
    function automatic hc_ctrl_t ctrl_for(input hc_cause_e cause);
        hc_ctrl_t c;
        case (cause)
            CAUSE_REDIRECT:                 c = '{pc_wen: 1'b1, ifid_wen: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
            CAUSE_LOAD_USE, CAUSE_MD_STALL: c = '{pc_wen: 1'b0, ifid_wen: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
            default:                        c = '{pc_wen: 1'b1, ifid_wen: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_controller_md_busy_timer.sv
// MULT/DIV HI/LO occupancy timer: loadable down-counter plus busy flag.
module md_busy_timer
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    hc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;

    // Timer holds remaining busy cycles minus one, so LAT=1 gives one BUSY cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            HC_IDLE: begin
                if (start) begin
                    state_d = HC_BUSY;
                    timer_d = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                end
            end
            HC_BUSY: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    state_d = HC_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HC_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign busy = (state_q == HC_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, MULT/DIV HI/LO occupancy and branch redirect.
// Optional STALL_CNT_EN adds stall_cnt/flush_cnt performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
`ifdef STALL_CNT_EN
    , parameter int unsigned PERF_W = PERF_W_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rf_raddr0_ID,
    input  logic [REG_ADDR_W-1:0] rf_raddr1_ID,
    input  logic                  rs_use_ID,
    input  logic                  rt_use_ID,
    input  logic                  md_use_ID,
    input  logic                  mem_ren_EX,
    input  logic [REG_ADDR_W-1:0] rf_waddr_EX,
    input  logic                  md_start_EX,
    input  logic                  md_is_div_EX,
    input  logic                  branch_taken_EX,
    output logic                  pc_wen,
    output logic                  ifid_wen,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  md_busy,
    output logic [CAUSE_W-1:0]    hazard_cause
`ifdef STALL_CNT_EN
    , output logic [PERF_W-1:0]   stall_cnt,
    output logic [PERF_W-1:0]     flush_cnt
`endif
);

    logic      timer_busy;
    logic      load_use;
    logic      md_stall;
    hc_cause_e cause;
    hc_ctrl_t  ctrl;

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start_EX),
        .is_div (md_is_div_EX),
        .busy   (timer_busy)
    );

    // A load writing $zero never creates a dependency.
    assign load_use = mem_ren_EX && (rf_waddr_EX != '0) &&
                      ((rs_use_ID && (rf_raddr0_ID == rf_waddr_EX)) ||
                       (rt_use_ID && (rf_raddr1_ID == rf_waddr_EX)));
    assign md_stall = md_use_ID && (timer_busy || md_start_EX);

    // Priority: redirect > load-use > md stall; reset squashes both pipeline registers.
    always_comb begin
        cause = CAUSE_NONE;
        if (branch_taken_EX) begin
            cause = CAUSE_REDIRECT;
        end else if (load_use) begin
            cause = CAUSE_LOAD_USE;
        end else if (md_stall) begin
            cause = CAUSE_MD_STALL;
        end
        if (rst) begin
            cause = CAUSE_NONE;
        end
        ctrl = ctrl_for(cause);
        if (rst) begin
            ctrl = '{pc_wen: 1'b0, ifid_wen: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
        end
    end

    assign pc_wen       = ctrl.pc_wen;
    assign ifid_wen     = ctrl.ifid_wen;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_flush   = ctrl.idex_flush;
    assign md_busy      = timer_busy && !rst;
    assign hazard_cause = CAUSE_W'(cause);

`ifdef STALL_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((cause == CAUSE_LOAD_USE) || (cause == CAUSE_MD_STALL)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (cause == CAUSE_REDIRECT) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Performance counters not built.
`endif

    // Illegal in a correct pipeline: md stall keeps a second MULT/DIV out, and a redirect squashes EX.
    a_no_start_while_busy: assert property (@(posedge clk) disable iff (rst)
        !(md_start_EX && timer_busy));
    a_no_start_with_redirect: assert property (@(posedge clk) disable iff (rst)
        !(md_start_EX && branch_taken_EX));

endmodule
